// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache.
package cache_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int OFFSET_W       = 4;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [WORD_W-1:0] word_t;

    // Byte address split. The tag/index boundary depends on the line count,
    // so both live together in tag_index and the top level slices them.
    typedef struct packed {
        logic [ADDR_W-OFFSET_W-1:0] tag_index;
        logic [1:0]                 word;
        logic [1:0]                 byte_off;
    } addr_fields_t;

endpackage

// File: rtl/cache_direct_mapped_if.sv
// CPU/memory-side bus of the cache. With CACHE_STATS_EN defined the bus
// also carries the hit/miss counters.
interface cache_direct_mapped_if;
    import cache_pkg::*;

    logic [ADDR_W-1:0] address;
    line_t             inData;
    word_t             out;
    logic              hit;
`ifdef CACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport master (output address, inData, input out, hit, hit_count, miss_count);
    modport slave  (input address, inData, output out, hit, hit_count, miss_count);
`else
    modport master (output address, inData, input out, hit);
    modport slave  (input address, inData, output out, hit);
`endif

endinterface

// File: rtl/cache_word_select.sv
// Picks one 32-bit word out of a 128-bit line; word 0 sits in the LSBs.
module cache_word_select
    import cache_pkg::*;
(
    input  line_t      line_i,
    input  logic [1:0] word_i,
    output word_t      word_o
);

    // 4:1 word multiplexer
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        word_o = line_i[WORD_W-1:0];
        case (word_i)
            2'd1:    word_o = line_i[2*WORD_W-1:WORD_W];
            2'd2:    word_o = line_i[3*WORD_W-1:2*WORD_W];
            2'd3:    word_o = line_i[4*WORD_W-1:3*WORD_W];
            default: word_o = line_i[WORD_W-1:0];
        endcase
    end

endmodule

// File: rtl/cache_direct_mapped.sv
// Direct-mapped, read-allocate cache with 128-bit lines. Hit/miss and the
// selected word are combinational; a miss forwards the memory line and
// writes it into the indexed slot at the next rising edge.
// Optional: define CACHE_STATS_EN to add hit_count/miss_count counters.
module cache_direct_mapped
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_direct_mapped_if.slave  bus
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    addr_fields_t       addr;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_byte_off;

    assign addr            = bus.address;
    assign index           = addr.tag_index[INDEX_W-1:0];
    assign tag             = addr.tag_index[ADDR_W-OFFSET_W-1:INDEX_W];
    assign unused_byte_off = ^addr.byte_off;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    logic  hit;
    word_t stored_word, fill_word;

    assign hit = valid_q[index] && (tag_q[index] == tag);

    cache_word_select u_sel_stored (
        .line_i (data_q[index]),
        .word_i (addr.word),
        .word_o (stored_word)
    );

    cache_word_select u_sel_fill (
        .line_i (bus.inData),
        .word_i (addr.word),
        .word_o (fill_word)
    );

    assign bus.hit = hit;
    assign bus.out = hit ? stored_word : fill_word;

    // Next valid vector: a miss allocates the indexed line
    always_comb begin
        valid_d = valid_q;
        if (!hit) begin
            valid_d[index] = 1'b1;
        end
    end

    // Valid bits: cleared asynchronously so every line misses after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays: written on a miss, held otherwise
    // NOTE: the arrays have no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (rst_n && !hit) begin
            tag_q[index]  <= tag;
            data_q[index] <= bus.inData;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Exactly one counter advances per cycle, wrapping modulo 2^32
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_direct_mapped.sv
// Self-checking bench for cache_direct_mapped: expected hit/out pairs are
// queued when an access is driven and compared once the outputs settle.
module tb_cache_direct_mapped;
    import cache_pkg::*;

    logic clk;
    logic rst_n;

    cache_direct_mapped_if bus ();

    cache_direct_mapped #(.NUM_LINES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic  hit;
        word_t out;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive an access, queue its expectation, then compare after settling.
    task automatic apply(input logic [31:0] a, input line_t d, input logic eh,
                         input word_t eo, input string name);
        exp_t e;
        string n;
        bus.address = a;
        bus.inData  = d;
        exp_q.push_back('{hit: eh, out: eo});
        name_q.push_back(name);
        #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_hit"}, {31'd0, bus.hit}, {31'd0, e.hit});
        check({n, "_out"}, bus.out, e.out);
    endtask

    // Advance to the next falling edge, passing exactly one rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    localparam line_t L_WS = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam line_t L_A  = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam line_t L_B  = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam line_t L_C  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam line_t L_D  = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    localparam line_t L_E  = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
    localparam line_t L_F  = {32'h55553333, 32'h55552222, 32'h55551111, 32'h55550000};

    word_t ws_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    initial begin
        rst_n       = 1'b1;
        bus.address = '0;
        bus.inData  = 128'h5;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_hit", {31'd0, bus.hit}, 32'd0);
        check("reset_out_fwd", bus.out, 32'h5);

        // Basic fill at address 0, then at 0x64 (index 6, word 1)
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h0,  128'h5, 1'b0, 32'h5, "miss_0");
        step();
        apply(32'h0,  128'h5, 1'b1, 32'h5, "hit_0");
        step();
        apply(32'h64, 128'h5, 1'b0, 32'h0, "miss_64");
        step();
        apply(32'h64, 128'h5, 1'b1, 32'h0, "hit_64");
        step();
        apply(32'h0,  128'h5, 1'b1, 32'h5, "rehit_0");

        // Word select across one line
        step();
        apply(32'h10, L_WS, 1'b0, 32'h11111111, "miss_10");
        for (int w = 0; w < 4; w++) begin
            step();
            apply(32'h10 + 32'(4 * w), L_WS, 1'b1, ws_words[w], $sformatf("ws_w%0d", w));
        end

        // Conflict: 0x020 and 0x120 share index 2
        step();
        apply(32'h020, L_A, 1'b0, 32'hA0A0A0A0, "cf_a_miss");
        step();
        apply(32'h020, L_A, 1'b1, 32'hA0A0A0A0, "cf_a_hit");
        step();
        apply(32'h120, L_B, 1'b0, 32'hB0B0B0B0, "cf_b_miss");
        step();
        apply(32'h128, L_B, 1'b1, 32'hB2B2B2B2, "cf_b_hit_w2");
        step();
        apply(32'h024, L_C, 1'b0, 32'hC1C1C1C1, "cf_a_evicted");

        // Asynchronous reset between edges while hitting
        step();
        apply(32'h10, L_WS, 1'b1, 32'h11111111, "pre_rst");
        rst_n = 1'b0;
        apply(32'h10, L_F,  1'b0, 32'h55550000, "rst_drop");
        rst_n = 1'b1;
        apply(32'h10, L_F,  1'b0, 32'h55550000, "post_rst_10");
        step();
        apply(32'h64, L_D, 1'b0, 32'hD1D1D1D1, "post_rst_64");
        step();
        apply(32'h0,  L_D, 1'b0, 32'hD0D0D0D0, "post_rst_0");
        step();
        apply(32'h120, L_D, 1'b0, 32'hD0D0D0D0, "post_rst_120");

        // Counter sequence: reset, one miss, three hits at 0x40
        step();
        rst_n = 1'b0;
        bus.address = 32'h40;
        bus.inData  = L_E;
        #1;
`ifdef CACHE_STATS_EN
        check("st_rst_hits", bus.hit_count, 32'd0);
        check("st_rst_miss", bus.miss_count, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        apply(32'h40, L_E, 1'b0, 32'hE0E0E0E0, "st_miss");
        for (int i = 0; i < 3; i++) begin
            step();
            apply(32'h4C, L_E, 1'b1, 32'hE3E3E3E3, $sformatf("st_hit%0d", i));
        end
        step();
`ifdef CACHE_STATS_EN
        check("st_hit_count", bus.hit_count, 32'd3);
        check("st_miss_count", bus.miss_count, 32'd1);
        rst_n = 1'b0;
        #1;
        check("st_clr_hits", bus.hit_count, 32'd0);
        check("st_clr_miss", bus.miss_count, 32'd0);
        rst_n = 1'b1;
`endif
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
